// File: rtl/risc5_mem_pkg.sv
// Shared types for the RISC5 data-side SRAM bridge: FSM states, access
// kinds and the active-low byte-enable encodings.
package risc5_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic KIND_RD = 1'b0;
    localparam logic KIND_WR = 1'b1;

    // sram_be_n is active low; bit 1 selects the upper byte of the halfword
    localparam logic [1:0] BE_WORD  = 2'b00;
    localparam logic [1:0] BE_UPPER = 2'b01;
    localparam logic [1:0] BE_LOWER = 2'b10;
    localparam logic [1:0] BE_NONE  = 2'b11;

    function automatic logic [31:0] place_hw(input logic upper, input logic [15:0] hw);
        return upper ? {hw, 16'h0000} : {16'h0000, hw};
    endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// Per-phase down-counter: reloaded to WAIT_CYCLES on phase entry, so a phase
// lasts WAIT_CYCLES+1 cycles and ends on the cycle the count reads zero.
module sram_phase_timer #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic last,
    output logic last_next
);

    localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] RELOAD = CW'(WAIT_CYCLES);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt;
        if (load) begin
            cnt_next = RELOAD;
        end else if (cnt != '0) begin
            cnt_next = cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    assign last      = (cnt == '0);
    assign last_next = (cnt_next == '0);

endmodule

// File: rtl/risc5_sram_bridge.sv
// Data-side bridge from the RISC5 load/store port to a 16-bit async SRAM:
// word accesses become two halfword phases, byte accesses one phase.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | no access in flight; a request is latched on this cycle
//   LO      | first SRAM phase (low halfword, or the only one for a byte)
//   HI      | second SRAM phase of a word access (high halfword)
//   DONE    | stallX released, inbus valid, core completes the access
module risc5_sram_bridge
    import risc5_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int SRAM_AW     = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [23:0]        adr,
    input  logic               mem_rd,
    input  logic               mem_wr,
    input  logic               ben,
    input  logic [31:0]        outbus,
    output logic [31:0]        inbus,
    output logic               stallX,
    output logic [SRAM_AW-1:0] sram_adr,
    output logic [15:0]        sram_dq_o,
    input  logic [15:0]        sram_dq_i,
    output logic               sram_dq_oe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic [1:0]         sram_be_n
);

    state_t state;
    state_t state_next;

    logic             req;
    logic             kind_q;
    logic             ben_q;
    logic [SRAM_AW:0] adr_q;
    logic [31:0]      data_q;

    logic             acc_kind;
    logic             acc_ben;
    logic [SRAM_AW:0] acc_adr;
    logic [31:0]      acc_data;

    logic phase_next;
    logic hi_next;
    logic load;
    logic last;
    logic last_next;

    logic [SRAM_AW-1:0] adr_next;
    logic [15:0]        dq_next;
    logic [1:0]         be_next;
    logic               ce_next;
    logic               oe_next;
    logic               we_next;
    logic               dq_oe_next;

    logic [15:0] lo_q;

    assign req    = mem_rd | mem_wr;
    assign stallX = req & (state != ST_DONE);

    // In IDLE the request is latched on the same edge that enters LO, so the
    // first phase's outputs are taken straight from the core's inputs.
    assign acc_kind = (state == ST_IDLE) ? (mem_wr ? KIND_WR : KIND_RD) : kind_q;
    assign acc_ben  = (state == ST_IDLE) ? ben          : ben_q;
    assign acc_adr  = (state == ST_IDLE) ? adr[SRAM_AW:0] : adr_q;
    assign acc_data = (state == ST_IDLE) ? outbus       : data_q;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (req)  state_next = ST_LO;
            ST_LO:   if (last) state_next = ben_q ? ST_DONE : ST_HI;
            ST_HI:   if (last) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kind_q <= KIND_RD;
            ben_q  <= 1'b0;
            adr_q  <= '0;
            data_q <= '0;
        end else if (state == ST_IDLE && req) begin
            kind_q <= acc_kind;
            ben_q  <= ben;
            adr_q  <= adr[SRAM_AW:0];
            data_q <= outbus;
        end
    end

    assign phase_next = (state_next == ST_LO) || (state_next == ST_HI);
    assign hi_next    = (state_next == ST_HI);
    assign load       = phase_next && (state_next != state);

    sram_phase_timer #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .last      (last),
        .last_next (last_next)
    );

    // Next values of the registered SRAM pins; write strobe lifts on the last
    // phase cycle so address and data are held past the rising we_n edge.
    always_comb begin
        adr_next   = sram_adr;
        dq_next    = sram_dq_o;
        be_next    = BE_NONE;
        ce_next    = 1'b1;
        oe_next    = 1'b1;
        we_next    = 1'b1;
        dq_oe_next = 1'b0;
        if (phase_next) begin
            ce_next = 1'b0;
            if (acc_ben) begin
                adr_next = acc_adr[SRAM_AW:1];
                be_next  = acc_adr[0] ? BE_UPPER : BE_LOWER;
                dq_next  = acc_adr[1] ? acc_data[31:16] : acc_data[15:0];
            end else begin
                adr_next = {acc_adr[SRAM_AW:2], hi_next};
                be_next  = BE_WORD;
                dq_next  = hi_next ? acc_data[31:16] : acc_data[15:0];
            end
            if (acc_kind == KIND_WR) begin
                dq_oe_next = 1'b1;
                we_next    = last_next;
            end else begin
                oe_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sram_adr   <= '0;
            sram_dq_o  <= '0;
            sram_be_n  <= BE_NONE;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
        end else begin
            sram_adr   <= adr_next;
            sram_dq_o  <= dq_next;
            sram_be_n  <= be_next;
            sram_ce_n  <= ce_next;
            sram_oe_n  <= oe_next;
            sram_we_n  <= we_next;
            sram_dq_oe <= dq_oe_next;
        end
    end

    // inbus is only updated at the end of a read's final phase, so it holds
    // across writes and is stable throughout DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lo_q  <= '0;
            inbus <= '0;
        end else if (kind_q == KIND_RD && last) begin
            if (state == ST_LO && !ben_q) begin
                lo_q <= sram_dq_i;
            end
            if (state == ST_LO && ben_q) begin
                inbus <= place_hw(adr_q[1], sram_dq_i);
            end
            if (state == ST_HI) begin
                inbus <= {sram_dq_i, lo_q};
            end
        end
    end

endmodule

// File: tb/tb_risc5_sram_bridge.sv
// Bench for risc5_sram_bridge: two instances (WAIT_CYCLES 1 and 2) on a shared
// halfword SRAM model, with a queue of expected inbus values per completion.
module tb_risc5_sram_bridge;

    logic        clk;
    logic        rst_n;
    logic [23:0] adr;
    logic        ben;
    logic [31:0] outbus;
    logic        mem_rd_a, mem_wr_a, mem_rd_b, mem_wr_b;

    logic [31:0] inbus_a, inbus_b;
    logic        stall_a, stall_b;
    logic [19:0] sram_adr_a, sram_adr_b;
    logic [15:0] dq_o_a, dq_o_b, dq_i_a, dq_i_b;
    logic        dq_oe_a, dq_oe_b;
    logic        ce_n_a, oe_n_a, we_n_a, ce_n_b, oe_n_b, we_n_b;
    logic [1:0]  be_n_a, be_n_b;

    logic [15:0] mem [0:1023];
    logic        pk_en;
    logic [9:0]  pk_idx;
    logic [15:0] pk_val;

    logic        sel;
    logic        s_stall, s_oe_n, s_we_n, s_ce_n;
    logic [1:0]  s_be_n;
    logic [31:0] s_inbus;

    logic [31:0] exp_q[$];
    logic [31:0] model_inbus;
    int          errors, checks;
    int          n_stall, n_oe, n_we, n_wefall;
    logic [1:0]  be_seen;

    risc5_sram_bridge #(.WAIT_CYCLES(1), .SRAM_AW(20)) dut_a (
        .clk(clk), .rst(rst_n), .adr(adr), .mem_rd(mem_rd_a), .mem_wr(mem_wr_a),
        .ben(ben), .outbus(outbus), .inbus(inbus_a), .stallX(stall_a),
        .sram_adr(sram_adr_a), .sram_dq_o(dq_o_a), .sram_dq_i(dq_i_a),
        .sram_dq_oe(dq_oe_a), .sram_ce_n(ce_n_a), .sram_oe_n(oe_n_a),
        .sram_we_n(we_n_a), .sram_be_n(be_n_a)
    );

    risc5_sram_bridge #(.WAIT_CYCLES(2), .SRAM_AW(20)) dut_b (
        .clk(clk), .rst(rst_n), .adr(adr), .mem_rd(mem_rd_b), .mem_wr(mem_wr_b),
        .ben(ben), .outbus(outbus), .inbus(inbus_b), .stallX(stall_b),
        .sram_adr(sram_adr_b), .sram_dq_o(dq_o_b), .sram_dq_i(dq_i_b),
        .sram_dq_oe(dq_oe_b), .sram_ce_n(ce_n_b), .sram_oe_n(oe_n_b),
        .sram_we_n(we_n_b), .sram_be_n(be_n_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign dq_i_a = (!ce_n_a && !oe_n_a) ? mem[sram_adr_a[9:0]] : 16'h0000;
    assign dq_i_b = (!ce_n_b && !oe_n_b) ? mem[sram_adr_b[9:0]] : 16'h0000;

    // SRAM captures on any clock edge that ends a cycle with ce_n and we_n low
    always @(posedge clk) begin
        if (pk_en) mem[pk_idx] <= pk_val;
        if (!ce_n_a && !we_n_a) begin
            if (!be_n_a[0]) mem[sram_adr_a[9:0]][7:0]  <= dq_o_a[7:0];
            if (!be_n_a[1]) mem[sram_adr_a[9:0]][15:8] <= dq_o_a[15:8];
        end
        if (!ce_n_b && !we_n_b) begin
            if (!be_n_b[0]) mem[sram_adr_b[9:0]][7:0]  <= dq_o_b[7:0];
            if (!be_n_b[1]) mem[sram_adr_b[9:0]][15:8] <= dq_o_b[15:8];
        end
    end

    always_comb begin
        s_stall = sel ? stall_b : stall_a;
        s_oe_n  = sel ? oe_n_b  : oe_n_a;
        s_we_n  = sel ? we_n_b  : we_n_a;
        s_ce_n  = sel ? ce_n_b  : ce_n_a;
        s_be_n  = sel ? be_n_b  : be_n_a;
        s_inbus = sel ? inbus_b : inbus_a;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic poke(input logic [9:0] idx, input logic [15:0] val);
        pk_idx = idx;
        pk_val = val;
        pk_en  = 1'b1;
        @(posedge clk);
        #1;
        pk_en = 1'b0;
    endtask

    task automatic drive(input bit wr, input bit bsel, input logic [23:0] a, input logic [31:0] d);
        logic [15:0] hw;
        adr    = a;
        ben    = bsel;
        outbus = d;
        if (sel) begin mem_rd_b = ~wr; mem_wr_b = wr; end
        else     begin mem_rd_a = ~wr; mem_wr_a = wr; end
        if (!wr) begin
            if (bsel) begin
                hw = mem[a[10:1]];
                model_inbus = a[1] ? {hw, 16'h0000} : {16'h0000, hw};
            end else begin
                model_inbus = {mem[{a[10:2], 1'b1}], mem[{a[10:2], 1'b0}]};
            end
        end
        exp_q.push_back(model_inbus);
    endtask

    task automatic wait_done(input string tag, input int exp_stall);
        logic        prev_we;
        bit          done;
        logic [31:0] exp;
        n_stall = 0; n_oe = 0; n_we = 0; n_wefall = 0;
        be_seen = 2'b11;
        prev_we = 1'b1;
        done    = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (!s_oe_n) n_oe++;
            if (!s_we_n) begin
                n_we++;
                if (prev_we) n_wefall++;
            end
            prev_we = s_we_n;
            if (!s_ce_n) be_seen = s_be_n;
            if (s_stall) begin
                n_stall++;
            end else begin
                done = 1'b1;
                if (exp_q.size() > 0) begin
                    exp = exp_q.pop_front();
                    chk({tag, "_inbus"}, s_inbus, exp);
                end else begin
                    chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
                end
                chk({tag, "_stall"}, 32'(n_stall), 32'(exp_stall));
            end
        end
        if (!done) chk({tag, "_timeout"}, {31'd0, done}, 32'd1);
        @(posedge clk);
        #1;
        mem_rd_a = 1'b0; mem_wr_a = 1'b0;
        mem_rd_b = 1'b0; mem_wr_b = 1'b0;
    endtask

    task automatic access(input string tag, input bit wr, input bit bsel,
                          input logic [23:0] a, input logic [31:0] d, input int exp_stall);
        drive(wr, bsel, a, d);
        wait_done(tag, exp_stall);
        chk({tag, "_be"}, 32'(be_seen), bsel ? (a[0] ? 32'h1 : 32'h2) : 32'h0);
    endtask

    initial begin
        errors = 0; checks = 0;
        rst_n = 1'b0; sel = 1'b0;
        adr = '0; ben = 1'b0; outbus = '0;
        mem_rd_a = 1'b0; mem_wr_a = 1'b0; mem_rd_b = 1'b0; mem_wr_b = 1'b0;
        pk_en = 1'b0; pk_idx = '0; pk_val = '0;
        model_inbus = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_inbus_a", inbus_a, 32'h0);
        chk("rst_strobes_a", 32'({ce_n_a, oe_n_a, we_n_a, dq_oe_a}), 32'hE);
        chk("rst_be_a", 32'(be_n_a), 32'h3);
        chk("rst_adr_a", 32'(sram_adr_a), 32'h0);
        chk("rst_dq_a", 32'(dq_o_a), 32'h0);
        chk("rst_inbus_b", inbus_b, 32'h0);
        chk("rst_strobes_b", 32'({ce_n_b, oe_n_b, we_n_b, dq_oe_b}), 32'hE);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        poke(10'h082, 16'h5678);
        poke(10'h083, 16'h1234);
        access("wrd_rd", 1'b0, 1'b0, 24'h000104, 32'h0, 5);
        chk("wrd_rd_oe_cycles", 32'(n_oe), 32'd4);
        chk("wrd_rd_value", inbus_a, 32'h12345678);

        access("wrd_wr", 1'b1, 1'b0, 24'h000200, 32'hDEADBEEF, 5);
        chk("wrd_wr_lo", 32'(mem[10'h100]), 32'hBEEF);
        chk("wrd_wr_hi", 32'(mem[10'h101]), 32'hDEAD);
        chk("wrd_wr_we_cycles", 32'(n_we), 32'd2);
        chk("wrd_wr_we_pulses", 32'(n_wefall), 32'd2);

        poke(10'h101, 16'hAB00);
        access("byte_rd", 1'b0, 1'b1, 24'h000203, 32'h0, 3);
        chk("byte_rd_value", inbus_a, 32'hAB000000);

        poke(10'h008, 16'h5A00);
        access("byte_wr", 1'b1, 1'b1, 24'h000010, 32'h00000077, 3);
        chk("byte_wr_mem", 32'(mem[10'h008]), 32'h5A77);
        chk("byte_wr_we_cycles", 32'(n_we), 32'd1);

        poke(10'h200, 16'hC3D4);
        poke(10'h201, 16'hA1B2);
        for (int i = 0; i < 4; i++) begin
            access($sformatf("lane%0d", i), 1'b0, 1'b1, 24'h000400 + 24'(i), 32'h0, 3);
        end

        // reset in the HI phase of a word write, then replay with req held
        poke(10'h180, 16'h0000);
        poke(10'h181, 16'h0000);
        adr = 24'h000300; ben = 1'b0; outbus = 32'hCAFEF00D; mem_wr_a = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_mid_we_low", 32'(we_n_a), 32'h0);
        chk("rst_mid_dq_hi", 32'(dq_o_a), 32'hCAFE);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_strobes", 32'({ce_n_a, oe_n_a, we_n_a, dq_oe_a}), 32'hE);
        chk("rst_mid_be", 32'(be_n_a), 32'h3);
        chk("rst_mid_inbus", inbus_a, 32'h0);
        chk("rst_mid_adr", 32'(sram_adr_a), 32'h0);
        pk_idx = 10'h180; pk_val = 16'h0000; pk_en = 1'b1;
        @(posedge clk);
        #1;
        pk_en = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_inbus = 32'h0;
        exp_q.push_back(model_inbus);
        wait_done("rst_replay", 5);
        chk("rst_replay_lo", 32'(mem[10'h180]), 32'hF00D);
        chk("rst_replay_hi", 32'(mem[10'h181]), 32'hCAFE);
        chk("rst_replay_we", 32'(n_we), 32'd2);

        sel = 1'b1;
        poke(10'h040, 16'h3344);
        poke(10'h041, 16'h1122);
        access("b2b_rd", 1'b0, 1'b0, 24'h000080, 32'h0, 7);
        chk("b2b_rd_oe_cycles", 32'(n_oe), 32'd6);
        access("b2b_wr", 1'b1, 1'b0, 24'h000090, 32'h99887766, 7);
        chk("b2b_wr_hold", inbus_b, 32'h11223344);
        chk("b2b_wr_lo", 32'(mem[10'h048]), 32'h7766);
        chk("b2b_wr_hi", 32'(mem[10'h049]), 32'h9988);
        chk("b2b_wr_we_cycles", 32'(n_we), 32'd4);
        chk("b2b_wr_we_pulses", 32'(n_wefall), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
